// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: checks alignment/funct3 and runs one word-aligned req/ack bus cycle per request.
// Optional bus watchdog enabled by defining DMEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic        oBusy,
    output logic        oDone,
    output logic        oMisaligned,
    output logic        oIllegal,
    output logic        oBusErr,
    output logic [31:0] oRData,
    output logic [1:0]  oAlignment,
    output logic [2:0]  oFunct3,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [31:0] oMemAddr,
    output logic [3:0]  oMemBE,
    output logic [31:0] oMemWData,
    input  logic        iMemAck,
    input  logic [31:0] iMemRData,
    output logic [1:0]  oDbgState
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      r_state;
    logic        r_write;
    logic        w_illegal;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Handshake: oMemReq rises on accept and the oMem* bundle is frozen until the
    // single-cycle iMemAck; the ack cycle also delivers iMemRData.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = 32'd0;
        if (iWrite) begin
            w_illegal = iFunct3[2] | (iFunct3[1:0] == 2'b11);
        end else begin
            w_illegal = (iFunct3[1:0] == 2'b11) | (iFunct3 == 3'b110);
        end
        w_misaligned = ((iFunct3[1:0] == 2'b10) && (iAddr[1:0] != 2'b00)) ||
                       ((iFunct3[1:0] == 2'b01) && iAddr[0]);
        if (iWrite) begin
            case (iFunct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << iAddr[1:0];
                    w_wdata = {4{iWData[7:0]}};
                end
                2'b01: begin
                    w_be    = iAddr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{iWData[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = iWData;
                end
            endcase
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] LP_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_timer;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            oDone       <= 1'b0;
            oMisaligned <= 1'b0;
            oIllegal    <= 1'b0;
            oRData      <= 32'd0;
            oAlignment  <= 2'd0;
            oFunct3     <= 3'd0;
            oMemReq     <= 1'b0;
            oMemWe      <= 1'b0;
            oMemAddr    <= 32'd0;
            oMemBE      <= 4'd0;
            oMemWData   <= 32'd0;
`ifdef DMEM_TIMEOUT_EN
            oBusErr     <= 1'b0;
            r_timer     <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iReq) begin
                        r_write    <= iWrite;
                        oAlignment <= iAddr[1:0];
                        oFunct3    <= iFunct3;
                        // Illegal takes priority so a bad funct3 never reports as misaligned.
                        if (w_illegal) begin
                            oIllegal <= 1'b1;
                            oDone    <= 1'b1;
                            r_state  <= ST_RESP;
                        end else if (w_misaligned) begin
                            oMisaligned <= 1'b1;
                            oDone       <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            oMemReq   <= 1'b1;
                            oMemWe    <= iWrite;
                            oMemAddr  <= {iAddr[31:2], 2'b00};
                            oMemBE    <= w_be;
                            oMemWData <= w_wdata;
                            r_state   <= ST_ACCESS;
`ifdef DMEM_TIMEOUT_EN
                            r_timer   <= 8'd0;
`endif
                        end
                    end
                end
                ST_ACCESS: begin
                    if (iMemAck) begin
                        if (!r_write) begin
                            oRData <= iMemRData;
                        end
                        oMemReq <= 1'b0;
                        oDone   <= 1'b1;
                        r_state <= ST_RESP;
`ifdef DMEM_TIMEOUT_EN
                    end else if (r_timer == LP_TIMEOUT_LAST) begin
                        oMemReq <= 1'b0;
                        oBusErr <= 1'b1;
                        oDone   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + 8'd1;
`endif
                    end
                end
                ST_RESP: begin
                    oDone       <= 1'b0;
                    oMisaligned <= 1'b0;
                    oIllegal    <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
                    oBusErr     <= 1'b0;
`endif
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifndef DMEM_TIMEOUT_EN
    assign oBusErr = 1'b0;
`endif

    assign oBusy     = (r_state != ST_IDLE);
    assign oDbgState = r_state;

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller for the multicycle/pipelined cores. It accepts one load or store request from the core, checks alignment and funct3, and drives a word-aligned request/acknowledge bus with byte enables and lane-replicated store data. On completion it returns the raw 32-bit word, the address alignment and the funct3 as registered values; the downstream load formatter turns these into the sign/zero-extended result.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: bus watchdog limit in cycles. Used only when DMEM_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- iCLK  in  1  core clock; all state changes on the rising edge
- iRST_N  in  1  reset, asynchronous, active-low
- iReq  in  1  access request; sampled only in IDLE
- iWrite  in  1  1 = store, 0 = load
- iFunct3  in  3  RV32I load/store funct3
- iAddr  in  32  byte address
- iWData  in  32  store data, right-justified
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle completion pulse, exactly one per accepted request
- oMisaligned  out  1  qualifies oDone: address misaligned for the access size
- oIllegal  out  1  qualifies oDone: funct3 invalid for the direction
- oBusErr  out  1  qualifies oDone: watchdog expired
- oRData  out  32  raw memory word of the last completed load
- oAlignment  out  2  iAddr[1:0] of the last accepted request
- oFunct3  out  3  iFunct3 of the last accepted request
- oMemReq  out  1  bus request, held until acknowledged
- oMemWe  out  1  bus write enable
- oMemAddr  out  32  {iAddr[31:2], 2'b00}
- oMemBE  out  4  byte enables
- oMemWData  out  32  lane-replicated store data
- iMemAck  in  1  bus acknowledge, one cycle; read data valid in the same cycle
- iMemRData  in  32  bus read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE with iReq=1: register iWrite, iFunct3, iAddr, iWData.
  - Check fails: go to RESP with the matching error flag. No bus cycle is issued.
  - Check passes: go to ACCESS.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value sets oIllegal. If an access is both illegal and misaligned, only oIllegal is set.
- Misaligned: word access with addr[1:0]!=0, or halfword access with addr[0]!=0.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Halfword: addr[1] ? 4'b1100 : 4'b0011.
  - Word, and every load: 4'b1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata unchanged.
  - Loads drive oMemWData=0 and oMemWe=0.
- ACCESS: oMemReq=1. All oMem* outputs stay stable until iMemAck. When iMemAck=1:
  - Capture iMemRData into oRData (loads only; stores leave oRData unchanged).
  - Drop oMemReq and go to RESP.
- RESP: oDone=1 for one cycle with the error flags valid, then return to IDLE. iReq is ignored in ACCESS and RESP.
- iMemAck is ignored in IDLE and RESP.
- oRData, oAlignment and oFunct3 hold their values until the next capture or accept.
- Reset value of every output is 0, and state is IDLE. Reset asserted mid-access forces IDLE and oMemReq=0 immediately, without waiting for iCLK; the pending request is lost and no oDone is produced.

## Timing
- Edge 0: iReq accepted. Cycle 1: oMemReq=1. If iMemAck=1 in cycle 1, oDone=1 in cycle 2. Minimum load/store latency is 2 cycles from accept to oDone.
- Each cycle of delay before iMemAck adds one cycle to the latency.
- Error path: oDone with the error flag in cycle 1 (latency 1), and oMemReq never rises.
- A new iReq can be accepted in the cycle after oDone, so the throughput is 1 request per 3 cycles.
- oDone and the error flags are registered outputs, high for exactly one cycle.

## Configuration
- DMEM_TIMEOUT_EN defined: an 8-bit counter clears on entry to ACCESS and increments every ACCESS cycle without iMemAck.
  - Reaching TIMEOUT_CYCLES: drop oMemReq, go to RESP, oBusErr=1, oRData unchanged.
  - An ack in the same cycle as the limit counts as success.
- Not defined: no counter; ACCESS waits indefinitely for iMemAck; oBusErr is tied to 0.

## Test plan
- LW at addr 0x100, ack in cycle 1 with rdata 0xDEADBEEF: oMemAddr=0x100, BE=1111; oDone in cycle 2; oRData=0xDEADBEEF, oAlignment=00, oFunct3=010.
- SB at addr 0x203, wdata 0x000000A5: oMemAddr=0x200, BE=1000, oMemWData=0xA5A5A5A5, oMemWe=1; single oDone, no error flags.
- SH at addr 0x301: oDone with oMisaligned=1 in cycle 1; oMemReq stays 0 throughout.
- Load with funct3=110: oIllegal=1. Store with funct3=100: oIllegal=1. No bus activity in either case.
- Ack delayed 5 cycles: oMem* outputs stable for 5 cycles and oDone in cycle 6. Repeat, asserting iRST_N=0 in the 3rd ACCESS cycle: oMemReq falls asynchronously, no oDone is produced, and state is IDLE.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack: oDone with oBusErr=1 after 4 ACCESS cycles, and oMemReq falls.
